// File: rtl/br_loop_scheduler_pkg.sv
// rtl/br_loop_scheduler_pkg.sv - shared types and TFHE defaults for the BR loop scheduler
package br_loop_scheduler_pkg;

   localparam int TFHE_LWE_K        = 834;
   localparam int TFHE_BATCH_PBS_NB = 8;
   localparam int BR_LOOP_W         = $clog2(TFHE_LWE_K);
   localparam int BR_PBS_W          = $clog2(TFHE_BATCH_PBS_NB + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } br_sched_state_e;

   typedef struct packed {
      logic [BR_LOOP_W-1:0] br_loop;
      logic [BR_PBS_W-1:0]  pbs_idx;
      logic                 first_loop;
      logic                 last_loop;
      logic                 last_pbs;
   } br_cmd_t;

endpackage

// File: rtl/br_loop_scheduler_if.sv
// rtl/br_loop_scheduler_if.sv - batch, command, completion and BSK signals of the scheduler
// master is the scheduler side, slave is the dispatcher/datapath/BSK side.
interface br_loop_scheduler_if
   import br_loop_scheduler_pkg::*;
#(
   parameter int LWE_K_W = BR_LOOP_W,
   parameter int BPBS_W  = BR_PBS_W
) ();

   logic               batch_vld;
   logic               batch_rdy;
   logic [BPBS_W-1:0]  batch_pbs_nb;
   logic               cmd_vld;
   logic               cmd_rdy;
   logic [LWE_K_W-1:0] cmd_br_loop;
   logic [BPBS_W-1:0]  cmd_pbs_idx;
   logic               cmd_first_loop;
   logic               cmd_last_loop;
   logic               cmd_last_pbs;
   logic               done_vld;
   logic               bsk_loop_avail;
   logic               bsk_loop_consumed;
   logic               batch_done;
   logic               err_cfg;
   logic               err_done;

   modport master (
      input  batch_vld, batch_pbs_nb, cmd_rdy, done_vld, bsk_loop_avail,
      output batch_rdy, cmd_vld, cmd_br_loop, cmd_pbs_idx, cmd_first_loop,
             cmd_last_loop, cmd_last_pbs, bsk_loop_consumed, batch_done,
             err_cfg, err_done
   );

   modport slave (
      output batch_vld, batch_pbs_nb, cmd_rdy, done_vld, bsk_loop_avail,
      input  batch_rdy, cmd_vld, cmd_br_loop, cmd_pbs_idx, cmd_first_loop,
             cmd_last_loop, cmd_last_pbs, bsk_loop_consumed, batch_done,
             err_cfg, err_done
   );

endinterface

// File: rtl/br_loop_scheduler_cmd_reg.sv
// rtl/br_loop_scheduler_cmd_reg.sv - valid/ready output register for BR commands
// The payload only changes on load, so a presented command holds until accepted.
module br_sched_cmd_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              out_rdy,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_data
);

   logic              vld_q, vld_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      vld_d  = vld_q & ~out_rdy;
      data_d = data_q;
      if (load) begin
         vld_d  = 1'b1;
         data_d = load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign out_vld  = vld_q;
   assign out_data = data_q;

endmodule

// File: rtl/br_loop_scheduler.sv
// rtl/br_loop_scheduler.sv - blind-rotation loop sequencer for one PBS batch
// Issues loop-major commands, limited to pbs_nb outstanding and gated by BSK slice availability.
module br_loop_scheduler
   import br_loop_scheduler_pkg::*;
#(
   parameter int LWE_K        = TFHE_LWE_K,
   parameter int BATCH_PBS_NB = TFHE_BATCH_PBS_NB,
   parameter int LWE_K_W      = $clog2(LWE_K),
   parameter int BPBS_W       = $clog2(BATCH_PBS_NB + 1)
) (
   input  logic               clk,
   input  logic               a_rst,
   br_loop_scheduler_if.master bus
);

   localparam int                 CMD_W     = LWE_K_W + BPBS_W + 3;
   localparam logic [LWE_K_W-1:0] LAST_LOOP = LWE_K_W'(LWE_K - 1);
   localparam logic [BPBS_W-1:0]  NB_MAX    = BPBS_W'(BATCH_PBS_NB);

   br_sched_state_e    state_q, state_d;
   logic [BPBS_W-1:0]  nb_q, nb_d;
   logic [BPBS_W-1:0]  pbs_q, pbs_d;
   logic [BPBS_W-1:0]  out_q, out_d;
   logic [LWE_K_W-1:0] loop_q, loop_d;
   logic               all_loaded_q, all_loaded_d;
   logic               batch_rdy_q, batch_rdy_d;
   logic               consumed_q, consumed_d;
   logic               err_cfg_q, err_cfg_d;
   logic               err_done_q, err_done_d;

   logic               cmd_vld, load, want_load, accept, nb_legal;
   logic               hs, done_ok, slot_free;
   logic [CMD_W-1:0]   cmd_data, load_data;
   logic [LWE_K_W-1:0] cur_loop, c_loop;
   logic [BPBS_W-1:0]  cur_pbs, cur_nb, c_pbs;
   logic               c_first, c_last_loop, c_last_pbs;

   assign {c_loop, c_pbs, c_first, c_last_loop, c_last_pbs} = cmd_data;

   always_comb begin
      state_d      = state_q;
      nb_d         = nb_q;
      loop_d       = loop_q;
      pbs_d        = pbs_q;
      all_loaded_d = all_loaded_q;
      err_cfg_d    = 1'b0;
      want_load    = 1'b0;
      load         = 1'b0;
      load_data    = '0;
      cur_loop     = loop_q;
      cur_pbs      = pbs_q;
      cur_nb       = nb_q;

      accept     = batch_rdy_q & bus.batch_vld;
      nb_legal   = (bus.batch_pbs_nb != '0) && (bus.batch_pbs_nb <= NB_MAX);
      hs         = cmd_vld & bus.cmd_rdy;
      slot_free  = ~cmd_vld | bus.cmd_rdy;
      // A done racing an issue is legal even when nothing was outstanding before.
      done_ok    = bus.done_vld & ((out_q != '0) | hs);
      out_d      = out_q + BPBS_W'(hs) - BPBS_W'(done_ok);
      err_done_d = bus.done_vld & ~done_ok;
      consumed_d = hs & c_last_pbs;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (nb_legal) begin
                  nb_d         = bus.batch_pbs_nb;
                  cur_nb       = bus.batch_pbs_nb;
                  cur_loop     = '0;
                  cur_pbs      = '0;
                  loop_d       = '0;
                  pbs_d        = '0;
                  all_loaded_d = 1'b0;
                  want_load    = 1'b1;
                  state_d      = ST_RUN;
               end else begin
                  err_cfg_d = 1'b1;
                  state_d   = ST_FIN;
               end
            end
         end
         ST_RUN: begin
            want_load = ~all_loaded_q;
            if (hs & c_last_loop & c_last_pbs) state_d = ST_DRAIN;
         end
         ST_DRAIN: if (out_q == '0) state_d = ST_FIN;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Window uses the post-update count, so a done this cycle opens a slot for next cycle.
      load = want_load & slot_free & bus.bsk_loop_avail & (out_d < cur_nb);
      if (load) begin
         load_data = {cur_loop, cur_pbs, cur_loop == '0, cur_loop == LAST_LOOP,
                      cur_pbs == cur_nb - BPBS_W'(1)};
         if (cur_pbs == cur_nb - BPBS_W'(1)) begin
            pbs_d = '0;
            if (cur_loop == LAST_LOOP) all_loaded_d = 1'b1;
            else                       loop_d = cur_loop + LWE_K_W'(1);
         end else begin
            pbs_d = cur_pbs + BPBS_W'(1);
         end
      end

      batch_rdy_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         state_q      <= ST_IDLE;
         nb_q         <= '0;
         loop_q       <= '0;
         pbs_q        <= '0;
         out_q        <= '0;
         all_loaded_q <= 1'b0;
         batch_rdy_q  <= 1'b0;
         consumed_q   <= 1'b0;
         err_cfg_q    <= 1'b0;
         err_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         nb_q         <= nb_d;
         loop_q       <= loop_d;
         pbs_q        <= pbs_d;
         out_q        <= out_d;
         all_loaded_q <= all_loaded_d;
         batch_rdy_q  <= batch_rdy_d;
         consumed_q   <= consumed_d;
         err_cfg_q    <= err_cfg_d;
         err_done_q   <= err_done_d;
      end
   end

   br_sched_cmd_reg #(.DATA_W(CMD_W)) u_cmd_reg (
      .clk       (clk),
      .rst       (a_rst),
      .load      (load),
      .load_data (load_data),
      .out_rdy   (bus.cmd_rdy),
      .out_vld   (cmd_vld),
      .out_data  (cmd_data)
   );

   assign bus.batch_rdy         = batch_rdy_q;
   assign bus.cmd_vld           = cmd_vld;
   assign bus.cmd_br_loop       = c_loop;
   assign bus.cmd_pbs_idx       = c_pbs;
   assign bus.cmd_first_loop    = c_first;
   assign bus.cmd_last_loop     = c_last_loop;
   assign bus.cmd_last_pbs      = c_last_pbs;
   assign bus.bsk_loop_consumed = consumed_q;
   assign bus.batch_done        = (state_q == ST_FIN);
   assign bus.err_cfg           = err_cfg_q;
   assign bus.err_done          = err_done_q;

endmodule

// File: tb/tb_br_loop_scheduler.sv
// tb/tb_br_loop_scheduler.sv - randomized bench for br_loop_scheduler against a loop/batch model
module tb_br_loop_scheduler;

   localparam int LWE_K   = 4;
   localparam int NB_MAX  = 8;
   localparam int LWE_K_W = $clog2(LWE_K);
   localparam int BPBS_W  = $clog2(NB_MAX + 1);

   logic clk = 1'b0;
   logic a_rst;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;

   br_loop_scheduler_if #(.LWE_K_W(LWE_K_W), .BPBS_W(BPBS_W)) bus ();

   br_loop_scheduler #(.LWE_K(LWE_K), .BATCH_PBS_NB(NB_MAX)) dut (
      .clk   (clk),
      .a_rst (a_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int outs_now();
      return int'({bus.batch_rdy, bus.cmd_vld, bus.cmd_br_loop, bus.cmd_pbs_idx,
                   bus.cmd_first_loop, bus.cmd_last_loop, bus.cmd_last_pbs,
                   bus.bsk_loop_consumed, bus.batch_done, bus.err_cfg, bus.err_done});
   endfunction

   function automatic int pay_now();
      return int'({bus.cmd_vld, bus.cmd_br_loop, bus.cmd_pbs_idx,
                   bus.cmd_first_loop, bus.cmd_last_loop, bus.cmd_last_pbs});
   endfunction

   task automatic wait_rdy();
      int n = 0;
      while (!bus.batch_rdy && n < 50) begin
         step();
         n++;
      end
      chk("rdy_before_batch", int'(bus.batch_rdy), 1);
   endtask

   // Datapath model: fixed completion latency, in order; commands expected loop-major.
   task automatic run_batch(input int nb, input int lat, input bit rnd_rdy,
                            input bit gap, input int abort_after);
      int due[$];
      int e_loop = 0, e_pbs = 0, issued = 0, outst = 0, max_out = 0;
      int n_cons = 0, errs = 0, done_cyc = -1, last_done = -1;
      int acc_cyc, first_vld = -1, last_hs = -1, bad_gap = 0;
      int gap_start = -1, loop2_cyc = -1, prev_pay = 0, pay;
      bit prev_hold = 1'b0, hs;

      bus.bsk_loop_avail = 1'b1;
      wait_rdy();
      bus.batch_pbs_nb = BPBS_W'(nb);
      bus.batch_vld    = 1'b1;
      acc_cyc = cyc;
      step();
      bus.batch_vld = 1'b0;

      for (int t = 0; t < 3000 && done_cyc < 0; t++) begin
         pay = pay_now();
         if (prev_hold) chk("hold_payload", pay, prev_pay);
         if (bus.cmd_vld && first_vld < 0) first_vld = cyc;
         if (bus.bsk_loop_consumed) n_cons++;
         if (bus.err_cfg || bus.err_done) errs++;
         if (bus.batch_done) done_cyc = cyc;

         if (gap) begin
            if (gap_start < 0 && bus.cmd_vld && int'(bus.cmd_br_loop) == 1 && bus.cmd_last_pbs)
               gap_start = cyc;
            if (loop2_cyc < 0 && bus.cmd_vld && int'(bus.cmd_br_loop) == 2) loop2_cyc = cyc;
            bus.bsk_loop_avail = !(gap_start >= 0 && cyc < gap_start + 10);
         end

         bus.cmd_rdy = rnd_rdy ? ($urandom_range(9, 0) < 7) : 1'b1;
         hs = bus.cmd_vld && bus.cmd_rdy;
         if (hs) begin
            chk("cmd_loop", int'(bus.cmd_br_loop), e_loop);
            chk("cmd_pbs", int'(bus.cmd_pbs_idx), e_pbs);
            chk("cmd_first", int'(bus.cmd_first_loop), int'(e_loop == 0));
            chk("cmd_last_loop", int'(bus.cmd_last_loop), int'(e_loop == LWE_K - 1));
            chk("cmd_last_pbs", int'(bus.cmd_last_pbs), int'(e_pbs == nb - 1));
            if (nb == 1 && last_hs >= 0 && cyc - last_hs != lat + 1) bad_gap++;
            last_hs = cyc;
            e_pbs++;
            if (e_pbs == nb) begin
               e_pbs = 0;
               e_loop++;
            end
            due.push_back(cyc + lat);
            outst++;
            issued++;
         end

         bus.done_vld = (due.size() > 0 && due[0] == cyc);
         if (bus.done_vld) begin
            void'(due.pop_front());
            outst--;
            last_done = cyc;
         end
         if (outst > max_out) max_out = outst;

         if (abort_after > 0 && issued == abort_after) begin
            a_rst = 1'b1;
            #1;
            chk("rst_outputs_zero", outs_now(), 0);
            bus.cmd_rdy  = 1'b0;
            bus.done_vld = 1'b0;
            step();
            #2;
            a_rst = 1'b0;
            step();
            chk("rst_rdy_release", int'(bus.batch_rdy), 1);
            chk("rst_no_cmd", int'(bus.cmd_vld), 0);
            chk("rst_no_done", int'(bus.batch_done), 0);
            return;
         end

         prev_hold = bus.cmd_vld && !bus.cmd_rdy;
         prev_pay  = pay;
         step();
      end

      bus.cmd_rdy  = 1'b0;
      bus.done_vld = 1'b0;
      chk("batch_timeout", int'(done_cyc >= 0), 1);
      chk("rdy_after_done", int'(bus.batch_rdy), 1);
      chk("done_one_pulse", int'(bus.batch_done), 0);
      chk("first_cmd_latency", first_vld - acc_cyc, 1);
      chk("cmd_count", issued, LWE_K * nb);
      chk("bsk_consumed_cnt", n_cons, LWE_K);
      chk("done_timing", done_cyc - last_done, 2);
      chk("window_limit", int'(max_out <= nb), 1);
      chk("no_errors", errs, 0);
      if (nb == 1 && !rnd_rdy) chk("nb1_spacing", bad_gap, 0);
      if (gap) chk("bsk_gap_resume", loop2_cyc, gap_start + 11);
   endtask

   task automatic run_bad(input int nb);
      int a;
      wait_rdy();
      bus.batch_pbs_nb = BPBS_W'(nb);
      bus.batch_vld    = 1'b1;
      a = cyc;
      step();
      bus.batch_vld = 1'b0;
      chk("bad_err_cfg", int'(bus.err_cfg), 1);
      chk("bad_batch_done", int'(bus.batch_done), 1);
      chk("bad_no_cmd", int'(bus.cmd_vld), 0);
      step();
      chk("bad_rdy_back", int'(bus.batch_rdy), 1);
      chk("bad_pulses_end", int'({bus.err_cfg, bus.batch_done, bus.cmd_vld}), 0);
      chk("bad_cycle", cyc - a, 2);
   endtask

   initial begin
      a_rst              = 1'b1;
      bus.batch_vld      = 1'b0;
      bus.batch_pbs_nb   = '0;
      bus.cmd_rdy        = 1'b0;
      bus.done_vld       = 1'b0;
      bus.bsk_loop_avail = 1'b1;
      step();
      step();
      chk("reset_outputs", outs_now(), 0);
      #2;
      a_rst = 1'b0;
      step();
      chk("reset_rdy_only", outs_now(), 1 << 14);

      run_batch(2, 3, 1'b0, 1'b0, 0);
      run_batch(1, 5, 1'b0, 1'b0, 0);
      run_batch(2, 3, 1'b0, 1'b1, 0);
      run_batch(3, 2, 1'b1, 1'b0, 0);
      run_bad(0);
      run_bad(9);

      wait_rdy();
      bus.done_vld = 1'b1;
      step();
      bus.done_vld = 1'b0;
      chk("idle_err_done", int'(bus.err_done), 1);
      step();
      chk("idle_err_done_pulse", int'(bus.err_done), 0);

      run_batch(1, 0, 1'b0, 1'b0, 0);
      run_batch(1, 5, 1'b0, 1'b0, 0);
      run_batch(8, 4, 1'b1, 1'b0, 5);
      run_batch(3, 3, 1'b0, 1'b0, 0);
      for (int i = 0; i < 6; i++)
         run_batch(int'($urandom_range(8, 1)), int'($urandom_range(6, 0)), 1'b1, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/br_loop_scheduler.md
# br_loop_scheduler

Sequences the blind-rotation (BR) loop of the PBS engine for one batch of ciphertexts at a time. For each of the LWE_K mask coefficients it issues one command per ciphertext of the batch to the BR datapath (CMUX/NTT pipeline), in order. It enforces the per-ciphertext loop dependency with an outstanding-command window, and gates every loop on availability of the matching bootstrapping-key (BSK) slice. It sits between the PBS batch dispatcher and the BR datapath and BSK buffer.

## Interface
- LWE_K, 834: BR loop iterations per PBS (LWE dimension).
- BATCH_PBS_NB, 8: maximum ciphertexts per batch.
- LWE_K_W, $clog2(LWE_K): loop index width (10 at default).
- BPBS_W, $clog2(BATCH_PBS_NB+1): batch count width (4 at default).
- clk  in  1  clock.
- a_rst  in  1  asynchronous, active-high reset.
- batch_vld  in  1  new batch request.
- batch_rdy  out  1  scheduler idle; batch accepted on vld&rdy.
- batch_pbs_nb  in  BPBS_W  ciphertexts in batch, legal 1..BATCH_PBS_NB.
- cmd_vld  out  1  BR command valid.
- cmd_rdy  in  1  datapath accepts command.
- cmd_br_loop  out  LWE_K_W  loop index 0..LWE_K-1.
- cmd_pbs_idx  out  BPBS_W  ciphertext index within batch.
- cmd_first_loop / cmd_last_loop  out  1 each  cmd_br_loop==0 / ==LWE_K-1.
- cmd_last_pbs  out  1  cmd_pbs_idx==pbs_nb-1.
- done_vld  in  1  datapath finished one command; always in issue order.
- bsk_loop_avail  in  1  BSK slice for current loop is loaded (level).
- bsk_loop_consumed  out  1  one-cycle pulse: last command of a loop accepted.
- batch_done  out  1  one-cycle pulse: all commands of batch completed.
- err_cfg  out  1  one-cycle pulse: illegal batch_pbs_nb accepted.
- err_done  out  1  one-cycle pulse: done_vld with nothing outstanding.

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: batch_rdy=1. On accept with legal nb: latch pbs_nb, clear loop/pbs counters, go to RUN. With nb==0 or nb>BATCH_PBS_NB: pulse err_cfg, go to FIN; no commands.
- RUN: linear command k = loop*pbs_nb + pbs. Command k depends on k-pbs_nb; completion is in order. Issue therefore allowed iff outstanding < pbs_nb and bsk_loop_avail.
- Counters advance on cmd_vld&cmd_rdy. pbs wraps at pbs_nb-1 and loop increments. On the last pbs of a loop, pulse bsk_loop_consumed. On the last pbs of loop LWE_K-1, go to DRAIN.
- outstanding counter (BPBS_W): +1 on issue handshake, -1 on done_vld; both in one cycle leaves it unchanged.
- DRAIN: wait for outstanding==0, then go to FIN.
- FIN: pulse batch_done for one cycle, return to IDLE.
- done_vld with outstanding==0 and no simultaneous issue: pulse err_done, counter not decremented.
- done_vld in any state is legal while outstanding>0, including IDLE after an abnormal flow.

## Timing
- Reset values: batch_rdy=0 during reset, 1 the first cycle after release (IDLE). All other outputs are 0; all counters are 0.
- Command outputs are registered. cmd_vld first rises the cycle after batch accept, if gating allows.
- Once cmd_vld=1, it and the payload hold stable until cmd_rdy. Gating is evaluated only when loading the next command; a drop of bsk_loop_avail never retracts a presented command.
- Back-to-back issue: one command per cycle while cmd_rdy=1 and the window is open.
- A done_vld in cycle t can enable a new cmd_vld in t+1.
- batch_done occurs one cycle after the cycle where outstanding reaches 0 in DRAIN.
- batch_rdy rises the cycle after batch_done.
- Reset mid-batch: immediate return to IDLE. Commands in flight are discarded and no batch_done is produced.

## Structure
- The shared package holds the state enum (br_sched_state_e) and a command struct: br_loop, pbs_idx, first/last flags.
- LWE_K and BATCH_PBS_NB defaults come from the TFHE parameter package.
- One natural sub-module: br_sched_cmd_reg, the valid/ready output register holding the payload.

## Test plan
- LWE_K=4, nb=2, cmd_rdy=1, done returned 3 cycles after issue, bsk_loop_avail=1 -> exactly 8 commands in order (0,0),(0,1),(1,0)…(3,1). 4 bsk_loop_consumed pulses, 1 batch_done; window never exceeds 2 outstanding.
- nb=1, done latency 5 -> one command per 6 cycles; each cmd issues the cycle after the previous done.
- bsk_loop_avail deasserted after loop 1 for 10 cycles -> no loop 2 command during that gap; resumes the cycle after reassertion. Payload is stable across random cmd_rdy stalls.
- batch_pbs_nb=0, then 9 -> err_cfg pulse and batch_done without any cmd_vld; batch_rdy back the next cycle.
- done_vld in IDLE -> err_done pulse, outstanding stays 0. done_vld and issue in the same cycle -> outstanding unchanged.
- a_rst asserted after 5 commands of an nb=8 batch -> all outputs 0 immediately; batch_rdy=1 after release; a new nb=3 batch completes normally.
